// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared state, opcode and datapath-select encodings for the RV32I control units
package rv_ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10;
    localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;
    localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011, ALU_SLT = 3'b101;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp and instruction fields to the ALU operation
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);
    logic [2:0] funct_ctl;

    // Only R-type (op5=1) with funct7b5 set selects subtract; addi ignores bit 30
    always_comb begin
        funct_ctl = (funct3 == 3'b000) ? ((op5 && funct7b5) ? ALU_SUB : ALU_ADD) :
                    (funct3 == 3'b010) ? ALU_SLT :
                    (funct3 == 3'b110) ? ALU_OR  :
                    (funct3 == 3'b111) ? ALU_AND : ALU_ADD;
        alu_control = (alu_op == ALUOP_ADD) ? ALU_ADD :
                      (alu_op == ALUOP_SUB) ? ALU_SUB : funct_ctl;
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencing FSM, PC write, immediate select and retired-instruction counter
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
    output logic [2:0]       ALUControl,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instret
);
    state_t     state, next;
    logic       pc_update, branch, mem_write, ir_write, reg_write, illegal, retire;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            instret <= '0;
        end else begin
            state   <= next;
            instret <= retire ? instret + CNT_W'(1) : instret;
        end
    end

    always_comb begin
        next      = state;
        pc_update = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        alu_op    = ALUOP_ADD;
        case (state)
            FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_write  = mem_ready;
                pc_update = mem_ready;
                next      = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_R:         next = EXECUTER;
                    OP_I:         next = EXECUTEI;
                    OP_BEQ:       next = BEQ;
                    OP_JAL:       next = JAL;
                    default: begin
                        next    = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                next    = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                next   = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
                next      = FETCH;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                next      = mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTER, EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = (state == EXECUTEI) ? SRCB_IMM : SRCB_RD2;
                alu_op  = ALUOP_FUNCT;
                next    = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                next      = FETCH;
            end
            BEQ: begin
                ALUSrcA = SRCA_RD1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
                next    = FETCH;
            end
            JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
                next      = ALUWB;
            end
            default: next = FETCH;
        endcase
    end

    // An illegal-opcode return from DECODE is the only FETCH entry that retires nothing
    assign retire = (next == FETCH) && (state inside {MEMWB, ALUWB, BEQ, MEMWRITE});

    assign PCWrite       = !rst && (pc_update || (branch && zero));
    assign MemWrite      = !rst && mem_write;
    assign IRWrite       = !rst && ir_write;
    assign RegWrite      = !rst && reg_write;
    assign illegal_instr = !rst && illegal;

    assign ImmSrc = (op == OP_SW)  ? 2'b01 :
                    (op == OP_BEQ) ? 2'b10 :
                    (op == OP_JAL) ? 2'b11 : 2'b00;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: cycle-by-cycle scoreboard of every controller output against hand-sequenced states
module tb_multicycle_control;
    localparam int CW = 4;

    logic          clk = 1'b0, rst = 1'b1;
    logic [6:0]    op = '0;
    logic [2:0]    funct3 = '0;
    logic          funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
    logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]    ALUControl;
    logic [CW-1:0] instret;

    typedef enum int {S_F, S_D, S_MA, S_MR, S_MWB, S_MW, S_ER, S_EI, S_AWB, S_BEQ, S_JAL} st_t;
    typedef logic [20:0] obs_t;

    obs_t          exp_q[$];
    logic [CW-1:0] cnt = '0;
    int            n_run = 0, n_fail = 0;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .ALUControl(ALUControl), .illegal_instr(illegal_instr), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input obs_t got, input obs_t want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h", tag, got, want);
        end
    endtask

    function automatic logic [2:0] alu_ref();
        case (funct3)
            3'b000:  return (op[5] && funct7b5) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs for a given state, inputs and retired count, built from the output table
    function automatic obs_t model(st_t s, logic mr, logic z, logic r, logic [CW-1:0] c);
        logic       pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
        logic [1:0] rs = 0, sa = 0, sb = 0, imm;
        logic [2:0] alu = 0;
        imm = (op == 7'b0100011) ? 2'd1 : (op == 7'b1100011) ? 2'd2 : (op == 7'b1101111) ? 2'd3 : 2'd0;
        case (s)
            S_F:   begin sb = 2; rs = 2; irw = mr; pcw = mr; end
            S_D:   begin sa = 1; sb = 1;
                         ill = !(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111}); end
            S_MA:  begin sa = 2; sb = 1; end
            S_MR:  adr = 1;
            S_MWB: begin rs = 1; rw = 1; end
            S_MW:  begin adr = 1; mw = 1; end
            S_ER:  begin sa = 2; alu = alu_ref(); end
            S_EI:  begin sa = 2; sb = 1; alu = alu_ref(); end
            S_AWB: rw = 1;
            S_BEQ: begin sa = 2; alu = 3'b001; pcw = z; end
            S_JAL: begin sa = 1; sb = 2; pcw = 1; end
            default: ;
        endcase
        if (r) {pcw, mw, irw, rw, ill} = '0;
        return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu, ill, c};
    endfunction

    task automatic cyc(input st_t s, input logic mr, input logic z, input logic r, input logic ret);
        mem_ready = mr;
        zero      = z;
        rst       = r;
        exp_q.push_back(model(s, mr, z, r, cnt));
        @(negedge clk);
        check(s.name(), {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                         ImmSrc, RegWrite, ALUControl, illegal_instr, instret}, exp_q.pop_front());
        @(posedge clk);
        #1;
        if (r) cnt = '0;
        else if (ret) cnt = cnt + 1'b1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
    endtask

    task automatic alu_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        set_instr(o, f3, f7);
        cyc(S_F, 1, 0, 0, 0);
        cyc(S_D, 1, 0, 0, 0);
        cyc(o[5] ? S_ER : S_EI, 1, 0, 0, 0);
        cyc(S_AWB, 1, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(S_F, 1, 0, 1, 0);
        cyc(S_F, 1, 1, 1, 0);
        // lw with a FETCH wait and a MEMREAD wait
        set_instr(7'b0000011, 3'b010, 0);
        cyc(S_F, 0, 0, 0, 0);
        cyc(S_F, 1, 0, 0, 0);
        cyc(S_D, 1, 0, 0, 0);
        cyc(S_MA, 1, 0, 0, 0);
        cyc(S_MR, 0, 0, 0, 0);
        cyc(S_MR, 1, 0, 0, 0);
        cyc(S_MWB, 1, 0, 0, 1);
        // lw at full speed
        cyc(S_F, 1, 0, 0, 0);
        cyc(S_D, 1, 0, 0, 0);
        cyc(S_MA, 1, 0, 0, 0);
        cyc(S_MR, 1, 0, 0, 0);
        cyc(S_MWB, 1, 0, 0, 1);
        // sw with two MEMWRITE wait cycles
        set_instr(7'b0100011, 3'b010, 0);
        cyc(S_F, 1, 0, 0, 0);
        cyc(S_D, 1, 0, 0, 0);
        cyc(S_MA, 1, 0, 0, 0);
        cyc(S_MW, 0, 0, 0, 0);
        cyc(S_MW, 0, 0, 0, 0);
        cyc(S_MW, 1, 0, 0, 1);
        // beq taken, then not taken
        set_instr(7'b1100011, 3'b000, 0);
        cyc(S_F, 1, 0, 0, 0);
        cyc(S_D, 1, 1, 0, 0);
        cyc(S_BEQ, 1, 1, 0, 1);
        cyc(S_F, 1, 0, 0, 0);
        cyc(S_D, 1, 0, 0, 0);
        cyc(S_BEQ, 1, 0, 0, 1);
        // ALU decode variants
        alu_instr(7'b0110011, 3'b000, 1);
        alu_instr(7'b0110011, 3'b000, 0);
        alu_instr(7'b0010011, 3'b000, 1);
        alu_instr(7'b0110011, 3'b010, 0);
        alu_instr(7'b0110011, 3'b110, 0);
        alu_instr(7'b0010011, 3'b111, 0);
        alu_instr(7'b0110011, 3'b100, 1);
        // jal
        set_instr(7'b1101111, 3'b000, 0);
        cyc(S_F, 1, 0, 0, 0);
        cyc(S_D, 1, 0, 0, 0);
        cyc(S_JAL, 1, 1, 0, 0);
        cyc(S_AWB, 1, 0, 0, 1);
        // illegal opcode returns to FETCH without retiring
        set_instr(7'b0000000, 3'b000, 0);
        cyc(S_F, 1, 0, 0, 0);
        cyc(S_D, 1, 0, 0, 0);
        cyc(S_F, 0, 0, 0, 0);
        // reset in the middle of a MEMWRITE wait
        set_instr(7'b0100011, 3'b000, 0);
        cyc(S_F, 1, 0, 0, 0);
        cyc(S_D, 1, 0, 0, 0);
        cyc(S_MA, 1, 0, 0, 0);
        cyc(S_MW, 0, 0, 0, 0);
        cyc(S_MW, 0, 0, 1, 0);
        cyc(S_F, 1, 0, 0, 0);
        cyc(S_D, 1, 0, 0, 0);
        cyc(S_MA, 1, 0, 0, 0);
        cyc(S_MW, 1, 0, 0, 1);
        // counter wrap: retire up to all-ones, then one more
        for (int i = 0; i < 20 && cnt != '1; i++) alu_instr(7'b0010011, 3'b110, 0);
        alu_instr(7'b0110011, 3'b111, 0);
        cyc(S_F, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
